// File: rtl/pb_up_counter_pkg.sv
// Shared types and default constants for the push-button up-counter slice.
// Imported by the interface, the debouncer and the counter top.
package pb_up_counter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } pb_state_t;

  localparam int WIDTH_DEF    = 7;
  localparam int CNT_MAX_DEF  = 99;
  localparam int DB_TICKS_DEF = 3;

endpackage

// File: rtl/pb_up_counter_if.sv
// Port bundle between the counter and its environment: divider wave and raw buttons in,
// count and status out. There is no valid/ready handshake; all signals are plain levels.
interface pb_up_counter_if
  import pb_up_counter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic             sclk_in;
  logic             btn_up;
  logic             btn_clr;
  logic             btn_run;
  logic [WIDTH-1:0] count;
  logic             running;
  logic             wrap;
  pb_state_t        state_dbg;
  logic [2:0]       db_dbg;

  // master: the board side driving buttons and the divider wave
  modport master (
    output sclk_in, btn_up, btn_clr, btn_run,
    input  count, running, wrap, state_dbg, db_dbg
  );

  modport slave (
    input  sclk_in, btn_up, btn_clr, btn_run,
    output count, running, wrap, state_dbg, db_dbg
  );

endinterface

// File: rtl/pb_debounce.sv
// One push button: 2-flop synchroniser, tick-sampled history debounce and a
// rising-edge press pulse on the debounced level.
module pb_debounce
  import pb_up_counter_pkg::*;
#(
  parameter int DB_TICKS = DB_TICKS_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic btn_raw,
  output logic db_level,
  output logic press
);

  logic                sync1;
  logic                sync2;
  logic                db_q;
  logic [DB_TICKS-1:0] hist;
  logic [DB_TICKS-1:0] hist_next;

  assign hist_next = {hist[DB_TICKS-2:0], sync2};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      hist     <= '0;
      db_level <= 1'b0;
      db_q     <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      db_q  <= db_level;
      // Level only moves when the whole history agrees; mixed histories hold it.
      if (tick) begin
        hist <= hist_next;
        if (&hist_next) begin
          db_level <= 1'b1;
        end else if (~|hist_next) begin
          db_level <= 1'b0;
        end
      end
    end
  end

  assign press = db_level & ~db_q;

endmodule

// File: rtl/pb_up_counter.sv
// Wrap-around up counter driven by debounced push buttons, stepping either on an
// up press or on every slow-clock tick while in free-run.
module pb_up_counter
  import pb_up_counter_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int MAX_COUNT = CNT_MAX_DEF,
  parameter int DB_TICKS  = DB_TICKS_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  pb_up_counter_if.slave   bus
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);

  logic             s1;
  logic             s2;
  logic             s3;
  logic             tick;
  logic             db_up;
  logic             db_clr;
  logic             db_run;
  logic             press_up;
  logic             press_clr;
  logic             press_run;
  logic             inc;
  pb_state_t        state;
  pb_state_t        state_next;
  logic [WIDTH-1:0] count_q;
  logic             running_q;
  logic             wrap_q;

  // Divider wave is asynchronous to clk; s3 only feeds the rising-edge detect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= bus.sclk_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign tick = s2 & ~s3;

  pb_debounce #(.DB_TICKS(DB_TICKS)) u_db_up (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .btn_raw  (bus.btn_up),
    .db_level (db_up),
    .press    (press_up)
  );

  pb_debounce #(.DB_TICKS(DB_TICKS)) u_db_clr (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .btn_raw  (bus.btn_clr),
    .db_level (db_clr),
    .press    (press_clr)
  );

  pb_debounce #(.DB_TICKS(DB_TICKS)) u_db_run (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .btn_raw  (bus.btn_run),
    .db_level (db_run),
    .press    (press_run)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Clear beats run so a simultaneous clr+run press always lands in IDLE.
  always_comb begin
    state_next = state;
    if (press_clr) begin
      state_next = ST_IDLE;
    end else if (press_run) begin
      case (state)
        ST_IDLE: state_next = ST_RUN;
        ST_RUN:  state_next = ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // A single OR keeps a coincident up press and run tick to one step.
  assign inc = press_up | ((state == ST_RUN) & tick);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q   <= '0;
      running_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      wrap_q    <= 1'b0;
      running_q <= (state_next == ST_RUN);
      if (press_clr) begin
        count_q <= '0;
      end else if (inc) begin
        if (count_q == MAX_VAL) begin
          count_q <= '0;
          wrap_q  <= 1'b1;
        end else begin
          count_q <= count_q + 1'b1;
        end
      end
    end
  end

  assign bus.count     = count_q;
  assign bus.running   = running_q;
  assign bus.wrap      = wrap_q;
  assign bus.state_dbg = state;
  assign bus.db_dbg    = {db_run, db_clr, db_up};

endmodule
